// File: rtl/word_packer_if.sv
// Narrow-in / wide-out stream bundle for the word packer.
interface word_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [IN_W*RATIO-1:0] out_data;
  logic [RATIO-1:0]      out_keep;
  logic                  out_last;

  // Stream source / sink side (drives beats, consumes words).
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );

  // Packer side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/word_packer.sv
// Narrow-to-wide packer: RATIO beats of IN_W bits become one OUT_W word.
// in_last flushes a partial word, zero-padded, with per-lane keep flags.

// One lane: merge the incoming beat into this lane when it is the target.
module word_packer_lane #(
  parameter int IN_W = 8
) (
  input  logic            sel,
  input  logic [IN_W-1:0] acc_d,
  input  logic            acc_k,
  input  logic [IN_W-1:0] in_d,
  output logic [IN_W-1:0] mrg_d,
  output logic            mrg_k
);
  assign mrg_d = sel ? in_d : acc_d;
  assign mrg_k = acc_k | sel;
endmodule

module word_packer #(
  parameter int IN_W      = 8,
  parameter int RATIO     = 4,
  parameter int MSB_FIRST = 0
) (
  input logic          clk,
  input logic          rst,
  word_packer_if.slave bus
);
  localparam int             CW       = $clog2(RATIO);
  localparam logic [CW-1:0]  LAST_CNT = CW'(RATIO - 1);

  logic [RATIO-1:0][IN_W-1:0] acc, mrg, out_q;
  logic [RATIO-1:0]           acc_keep, mrg_keep, keep_q;
  logic [CW-1:0]              cnt, lane;
  logic                       vld_q, last_q;
  logic                       in_hs, out_hs, emit;

  // Backpressure depends only on the output register, never on in_valid.
  assign bus.in_ready = ~vld_q | bus.out_ready;
  assign in_hs        = bus.in_valid & bus.in_ready;
  assign out_hs       = vld_q & bus.out_ready;
  assign emit         = in_hs & ((cnt == LAST_CNT) | bus.in_last);

  // Beat counter maps to a lane; MSB_FIRST mirrors the lane order.
  always_comb begin
    lane = cnt;
    if (MSB_FIRST != 0) lane = LAST_CNT - cnt;
  end

  for (genvar g = 0; g < RATIO; g++) begin : g_lane
    word_packer_lane #(.IN_W(IN_W)) u_lane (
      .sel   (lane == CW'(g)),
      .acc_d (acc[g]),
      .acc_k (acc_keep[g]),
      .in_d  (bus.in_data),
      .mrg_d (mrg[g]),
      .mrg_k (mrg_keep[g])
    );
  end

  // Accumulate beats; on emit load the output register and restart at lane 0.
  // Output loads take precedence over the drain so back-to-back words never bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      acc_keep <= '0;
      cnt      <= '0;
      out_q    <= '0;
      keep_q   <= '0;
      last_q   <= 1'b0;
      vld_q    <= 1'b0;
    end else begin
      if (out_hs) vld_q <= 1'b0;
      if (in_hs) begin
        if (emit) begin
          out_q    <= mrg;
          keep_q   <= mrg_keep;
          last_q   <= bus.in_last;
          vld_q    <= 1'b1;
          acc      <= '0;
          acc_keep <= '0;
          cnt      <= '0;
        end else begin
          acc      <= mrg;
          acc_keep <= mrg_keep;
          cnt      <= cnt + 1'b1;
        end
      end
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.out_data  = out_q;
  assign bus.out_keep  = keep_q;
  assign bus.out_last  = last_q;
endmodule

// File: tb/tb_word_packer.sv
// Self-checking bench: LSB-first and MSB-first packers fed the same stream,
// table-driven vectors plus hand sequences for stall, full-rate and reset.
module tb_word_packer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  word_packer_if #(.IN_W(8), .RATIO(4)) ia ();
  word_packer_if #(.IN_W(8), .RATIO(4)) ib ();

  assign ia.in_valid = in_valid;  assign ib.in_valid = in_valid;
  assign ia.in_data  = in_data;   assign ib.in_data  = in_data;
  assign ia.in_last  = in_last;   assign ib.in_last  = in_last;
  assign ia.out_ready = out_ready; assign ib.out_ready = out_ready;

  word_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) u_a (.clk(clk), .rst(rst), .bus(ia.slave));
  word_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) u_b (.clk(clk), .rst(rst), .bus(ib.slave));

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  typedef struct packed {
    logic [3:0][7:0] b;   // b[j] is beat j
    logic [2:0]      n;
    logic            last;
    logic [31:0]     da;
    logic [3:0]      ka;
    logic [31:0]     db;
    logic [3:0]      kb;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Scoreboard: compare every accepted output word against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ia.out_valid && ia.out_ready) begin
      if (qa.size() == 0) chk("a_unexpected_word", ia.out_data, 32'hxxxxxxxx);
      else begin
        e = qa.pop_front();
        chk("a_data", ia.out_data, e.d);
        chk("a_keep", {28'd0, ia.out_keep}, {28'd0, e.k});
        chk("a_last", {31'd0, ia.out_last}, {31'd0, e.l});
      end
    end
    if (!rst && ib.out_valid && ib.out_ready) begin
      if (qb.size() == 0) chk("b_unexpected_word", ib.out_data, 32'hxxxxxxxx);
      else begin
        e = qb.pop_front();
        chk("b_data", ib.out_data, e.d);
        chk("b_keep", {28'd0, ib.out_keep}, {28'd0, e.k});
        chk("b_last", {31'd0, ib.out_last}, {31'd0, e.l});
      end
    end
  end

  // Full-rate observation window.
  logic stream_on = 1'b0;
  int   stamps[$];
  int   ir_low = 0;
  always @(negedge clk) begin
    if (stream_on) begin
      if (ia.out_valid) stamps.push_back(cyc);
      if (!ia.in_ready) ir_low++;
    end
  end

  // Present one beat and hold it until accepted (bounded).
  task automatic beat(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    forever begin
      @(negedge clk);
      if (ia.in_ready && ib.in_ready) break;
      n++;
      if (n > 200) begin
        chk("beat_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input logic [31:0] da, input logic [3:0] ka,
                      input logic [31:0] db, input logic [3:0] kb, input logic l);
    qa.push_back('{d: da, k: ka, l: l});
    qb.push_back('{d: db, k: kb, l: l});
  endtask

  initial begin
    tbl[0] = '{b: 32'h44332211, n: 3'd4, last: 1'b0, da: 32'h44332211, ka: 4'hF, db: 32'h11223344, kb: 4'hF};
    tbl[1] = '{b: 32'h0000BBAA, n: 3'd2, last: 1'b1, da: 32'h0000BBAA, ka: 4'h3, db: 32'hAABB0000, kb: 4'hC};
    tbl[2] = '{b: 32'h00000001, n: 3'd1, last: 1'b1, da: 32'h00000001, ka: 4'h1, db: 32'h01000000, kb: 4'h8};
    tbl[3] = '{b: 32'h00C3C2C1, n: 3'd3, last: 1'b1, da: 32'h00C3C2C1, ka: 4'h7, db: 32'hC1C2C300, kb: 4'hE};
    tbl[4] = '{b: 32'h0D0C0B0A, n: 3'd4, last: 1'b1, da: 32'h0D0C0B0A, ka: 4'hF, db: 32'h0A0B0C0D, kb: 4'hF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, ia.out_valid}, 32'd0);
    chk("rst_out_data", ia.out_data, 32'd0);
    chk("rst_out_keep", {28'd0, ia.out_keep}, 32'd0);
    chk("rst_out_last", {31'd0, ib.out_last}, 32'd0);
    chk("rst_in_ready", {31'd0, ia.in_ready}, 32'd1);
    rst = 1'b0;

    // Table vectors, back-to-back, out_ready=1
    for (int i = 0; i < 5; i++) begin
      push(tbl[i].da, tbl[i].ka, tbl[i].db, tbl[i].kb, tbl[i].last);
      for (int j = 0; j < int'(tbl[i].n); j++)
        beat(tbl[i].b[j], tbl[i].last && (j == int'(tbl[i].n) - 1));
      chk($sformatf("lat_valid_%0d", i), {31'd0, ia.out_valid}, 32'd1);
      chk($sformatf("lat_data_%0d", i), ia.out_data, tbl[i].da);
    end
    repeat (3) @(posedge clk);
    #1;

    // Stall: word held while out_ready=0, then released
    out_ready = 1'b0;
    push(32'h44332211, 4'hF, 32'h11223344, 4'hF, 1'b0);
    beat(8'h11, 1'b0); beat(8'h22, 1'b0); beat(8'h33, 1'b0); beat(8'h44, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (10) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, ia.in_ready}, 32'd0);
      chk("stall_data", ia.out_data, 32'h44332211);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(32'h88776655, 4'hF, 32'h55667788, 4'hF, 1'b0);
    beat(8'h55, 1'b0); beat(8'h66, 1'b0); beat(8'h77, 1'b0); beat(8'h88, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Full-rate stream of 16 beats
    for (int w = 0; w < 4; w++) begin
      logic [31:0] d;
      d = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      push(d, 4'hF, {d[7:0], d[15:8], d[23:16], d[31:24]}, 4'hF, 1'b0);
    end
    stream_on = 1'b1;
    for (int k = 0; k < 16; k++) beat(8'(k), 1'b0);
    repeat (2) @(posedge clk);
    #1;
    stream_on = 1'b0;
    chk("stream_words", stamps.size(), 32'd4);
    chk("stream_in_ready_low", ir_low, 32'd0);
    for (int s = 1; s < stamps.size(); s++)
      chk("stream_spacing", stamps[s] - stamps[s-1], 32'd4);

    // Reset mid-word discards the partial beats
    beat(8'h5A, 1'b0); beat(8'hA5, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", {31'd0, ia.out_valid}, 32'd0);
    chk("mid_rst_keep", {28'd0, ib.out_keep}, 32'd0);
    chk("mid_rst_data", ia.out_data, 32'd0);
    rst = 1'b0;
    push(32'h04030201, 4'hF, 32'h01020304, 4'hF, 1'b0);
    beat(8'h01, 1'b0); beat(8'h02, 1'b0); beat(8'h03, 1'b0); beat(8'h04, 1'b0);

    // Drain and confirm every expected word appeared
    for (int t = 0; t < 100 && (qa.size() != 0 || qb.size() != 0); t++) @(posedge clk);
    repeat (2) @(posedge clk);
    chk("qa_empty", qa.size(), 32'd0);
    chk("qb_empty", qb.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/word_packer.md
Name: word_packer

Overview:
- Parametrised narrow-to-wide packer: gathers RATIO input beats of IN_W bits each and presents them as one concatenated output word of IN_W*RATIO bits.
- Both sides use valid/ready handshakes.
- An input `in_last` flushes a partial word, zero-padded, with per-lane keep flags.
- Sits between byte-oriented sources and wide datapath registers. Successor to the fixed-width reset/concatenation register blocks, now generalised in width, ratio and lane order.

Parameters:
- IN_W, 8, input beat width in bits (>=1).
- RATIO, 4, input beats per output word (>=2); OUT_W = IN_W*RATIO.
- MSB_FIRST, 0, lane order. 0: beat k goes to lane k (bits k*IN_W +: IN_W). 1: beat k goes to lane RATIO-1-k.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  IN_W  input beat.
- in_last  in  1  final beat of packet; forces emit of the current word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  IN_W*RATIO  packed word.
- out_keep  out  RATIO  per-lane valid flag, indexed by lane.
- out_last  out  1  word contains the packet's last beat.

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out_last=0, out_keep={RATIO{1'b0}}, out_data={OUT_W{1'b0}}, accumulator={OUT_W{1'b0}}, acc_keep=0, beat count=0.
  - rst has priority over all other inputs.
  - A partially filled word is discarded; no emit.
- Count register: width $clog2(RATIO); range 0..RATIO-1; wraps to 0 after a full or flushed word.
- in_ready = ~out_valid | out_ready. This is combinational and identical for every beat; no combinational path from in_valid to in_ready.
- On input handshake, with lane L = count (MSB_FIRST=0) or RATIO-1-count (MSB_FIRST=1):
  - Write in_data into lane L of the accumulator.
  - Set acc_keep[L].
- Emit condition: handshake and (count==RATIO-1 or in_last). On emit:
  - out_data <= accumulator with the current beat merged in.
  - out_keep <= acc_keep with bit L set.
  - out_last <= in_last; out_valid <= 1.
  - Accumulator and acc_keep clear to zero; count <= 0.
  - Unfilled lanes in out_data are 0; their out_keep bits are 0.
- Non-emit handshake: count <= count+1; outputs unchanged.
- Output handshake (out_valid & out_ready) with no emit in the same cycle: out_valid <= 0. out_data, out_keep and out_last hold their values; they are don't-care to the consumer.
- Simultaneous output handshake and emit: the new word loads and out_valid stays 1, giving full throughput of one word every RATIO cycles with no bubble.
- Stalls:
  - out_valid=1 and out_ready=0 → in_ready=0.
  - Accumulator, count and outputs hold.
  - out_data/out_keep/out_last stable while out_valid & ~out_ready (AXI-style hold).
- Latency: word visible on out_* the cycle after the handshake of its final beat.
- in_last on the first beat → single-lane word: out_keep has exactly one bit set.
- in_last on beat RATIO-1 → full word with out_last=1.
- in_valid=0 → no state change except the output drain.
- Idle output values are not required to be zero after drain; only reset zeroes them.

Test Plan:
- Reset, then IN_W=8, RATIO=4, MSB_FIRST=0; send 0x11,0x22,0x33,0x44 back-to-back, out_ready=1 → one cycle after beat 4: out_data=32'h44332211, out_keep=4'b1111, out_last=0, out_valid for 1 cycle.
- Same stream with MSB_FIRST=1 → out_data=32'h11223344, out_keep=4'b1111.
- Send 0xAA,0xBB with in_last on 0xBB → out_data=32'h0000BBAA, out_keep=4'b0011, out_last=1; the next word starts at lane 0.
- Hold out_ready=0 while a word is pending and in_valid=1 → in_ready=0, out_data stable for 10 cycles. Release: the word accepts, and the next 4 beats produce 32'h88776655 with no lost or duplicated beat.
- Continuous stream of 16 beats 0x00..0x0F, out_ready=1 → 4 words 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C. out_valid asserted every 4th cycle with no stall; in_ready constantly 1.
- Assert rst after 2 beats (0x5A,0xA5) → out_valid=0, out_keep=0, out_data=0. The next 4 beats 0x01..0x04 yield 32'h04030201; the discarded beats never appear.
